// File: rtl/uart_rx_sipo.sv
// UART receiver: two-flop synchroniser, oversampled 3-tap majority bit decision,
// 11-bit frame (start, 8 data LSB-first, parity, stop) to parallel byte plus status.
module uart_rx_sipo #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       baud_clk,
    input  logic       rst_n,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SAMP_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] DECIDE    = TW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e        state;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic          samp_a;
    logic          samp_b;
    logic [7:0]    shift_reg;
    logic          par_bit;

    logic majority;
    logic decide;
    logic par_mismatch;

    // Third tap is the live rx_s value at the decision tick.
    always_comb begin
        majority     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        decide       = (tick_cnt == DECIDE);
        par_mismatch = ((^shift_reg) ^ PARITY_ODD) != par_bit;
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state         <= StIdle;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            samp_a        <= 1'b1;
            samp_b        <= 1'b1;
            shift_reg     <= 8'h00;
            par_bit       <= 1'b0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            active_flag   <= 1'b0;
            done_flag     <= 1'b0;
        end else begin
            rx_meta    <= data_rx;
            rx_s       <= rx_meta;
            data_valid <= 1'b0;
            done_flag  <= 1'b0;

            // Free-running bit-period counter while a frame is in flight; decision ticks
            // therefore stay exactly one bit period apart.
            if (state != StIdle && state != StWaitHigh) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                if (tick_cnt == SAMP_A) samp_a <= rx_s;
                if (tick_cnt == SAMP_B) samp_b <= rx_s;
            end

            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        tick_cnt    <= '0;
                        bit_cnt     <= '0;
                        active_flag <= 1'b1;
                        state       <= StStart;
                    end
                end
                StStart: begin
                    if (decide) begin
                        if (majority) begin
                            active_flag <= 1'b0;
                            state       <= StIdle;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_reg <= {majority, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= StParity;
                    end
                end
                StParity: begin
                    if (decide) begin
                        par_bit <= majority;
                        state   <= StStop;
                    end
                end
                StStop: begin
                    if (decide) begin
                        data_out      <= shift_reg;
                        parity_error  <= par_mismatch;
                        framing_error <= ~majority;
                        data_valid    <= 1'b1;
                        done_flag     <= 1'b1;
                        active_flag   <= 1'b0;
                        // Leaving mid-stop-bit lets a zero-gap next start edge be caught.
                        state         <= majority ? StIdle : StWaitHigh;
                    end
                end
                StWaitHigh: begin
                    if (rx_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: vector table, corner-case sequences and
// randomized frames scored against a frame-level reference model.
module tb_uart_rx_sipo;

    localparam int unsigned OS   = 16;
    localparam bit          PODD = 1'b0;

    logic       baud_clk;
    logic       rst_n;
    logic       data_rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       active_flag;
    logic       done_flag;

    uart_rx_sipo #(
        .OVERSAMPLE(OS),
        .PARITY_ODD(PODD)
    ) dut (
        .baud_clk     (baud_clk),
        .rst_n        (rst_n),
        .data_rx      (data_rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    int unsigned cyc = 0;
    always @(posedge baud_clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        logic        dv;
        logic        done;
    } pulse_t;

    pulse_t pulses[$];
    int     rd = 0;

    // Any cycle with either strobe high is logged for the main process to score.
    always @(negedge baud_clk) begin
        if (data_valid || done_flag)
            pulses.push_back('{cyc, data_out, parity_error, framing_error, data_valid, done_flag});
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge baud_clk);
            #1;
        end
    endtask

    function automatic int pending();
        return pulses.size() - rd;
    endfunction

    // Reference rule: received parity must equal XOR of the byte, inverted for odd parity.
    function automatic logic model_pe(input logic [7:0] d, input logic par);
        return par != ((^d) ^ PODD);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            data_rx = bits[i];
            tick(OS);
        end
    endtask

    task automatic expect_one(input string tag, input logic [7:0] d, input logic pe,
                              input logic fe);
        pulse_t p;
        chk({tag, "_count"}, pending(), 1);
        if (pending() >= 1) begin
            p = pulses[rd];
            chk({tag, "_data"}, p.d, d);
            chk({tag, "_perr"}, p.pe, pe);
            chk({tag, "_ferr"}, p.fe, fe);
            chk({tag, "_strobes"}, {p.dv, p.done}, 2'b11);
        end
        rd = pulses.size();
    endtask

    vec_t vecs[6];
    exp_t exp_q[$];

    initial begin
        logic [10:0] bits;
        int unsigned t0;
        bit          seen;
        pulse_t      p0;
        pulse_t      p1;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[4] = '{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};

        // Reset values
        rst_n   = 1'b0;
        data_rx = 1'b1;
        tick(3);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_flags", {data_valid, parity_error, framing_error, active_flag, done_flag},
            5'b0);
        rst_n = 1'b1;
        tick(4);

        // 0xA5 with active_flag tracking and latency window
        chk("a5_active_before", active_flag, 1'b0);
        bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        t0   = cyc;
        for (int i = 0; i < 11; i++) begin
            data_rx = bits[i];
            tick(OS / 2);
            if (i == 0 || i == 9 || i == 10) chk($sformatf("a5_active_bit%0d", i), active_flag, 1'b1);
            tick(OS / 2);
        end
        data_rx = 1'b1;
        tick(2 * OS);
        chk("a5_active_after", active_flag, 1'b0);
        if (pending() >= 1) begin
            chk("a5_latency_window",
                (pulses[rd].cyc - t0 >= OS * 21 / 2 + 2) && (pulses[rd].cyc - t0 <= OS * 21 / 2 + 6),
                1'b1);
        end
        expect_one("a5", 8'hA5, 1'b0, 1'b0);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].d, vecs[v].par, vecs[v].stop);
            data_rx = 1'b1;
            tick(2 * OS);
            expect_one($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_pe, vecs[v].exp_fe);
            chk($sformatf("vec%0d_perr_hold", v), parity_error, vecs[v].exp_pe);
            chk($sformatf("vec%0d_ferr_hold", v), framing_error, vecs[v].exp_fe);
        end

        // 0x5A with stop low then line held low for 40 ticks
        send_frame(8'h5A, 1'b0, 1'b0);
        tick(40);
        chk("brk_active_low", active_flag, 1'b0);
        expect_one("brk", 8'h5A, 1'b0, 1'b1);
        data_rx = 1'b1;
        tick(2 * OS);
        chk("brk_no_second", pending(), 0);

        // Four-tick glitch on idle line
        data_rx = 1'b0;
        tick(4);
        data_rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * OS; i++) begin
            tick(1);
            if (active_flag) seen = 1'b1;
        end
        chk("glitch_start_seen", seen, 1'b1);
        chk("glitch_no_valid", pending(), 0);
        chk("glitch_data_kept", data_out, 8'h5A);
        chk("glitch_active_end", active_flag, 1'b0);

        // Back-to-back 0x00 then 0xFF, zero idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        data_rx = 1'b1;
        tick(2 * OS);
        chk("b2b_count", pending(), 2);
        if (pending() >= 2) begin
            p0 = pulses[rd];
            p1 = pulses[rd + 1];
            chk("b2b_first_data", p0.d, 8'h00);
            chk("b2b_second_data", p1.d, 8'hFF);
            chk("b2b_errors", {p0.pe, p0.fe, p1.pe, p1.fe}, 4'b0);
            chk("b2b_spacing", p1.cyc - p0.cyc, 11 * OS);
        end
        rd = pulses.size();

        // Reset asserted during data bit 4 of 0x77
        bits    = {1'b1, 1'b0, 8'h77, 1'b0};
        data_rx = 1'b0;
        tick(OS);
        for (int i = 1; i <= 4; i++) begin
            data_rx = bits[i];
            tick(OS);
        end
        data_rx = bits[5];
        tick(OS / 2);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_flags", {data_valid, parity_error, framing_error, active_flag, done_flag},
            5'b0);
        data_rx = 1'b1;
        rst_n   = 1'b1;
        tick(3 * OS);
        chk("midrst_no_valid", pending(), 0);
        send_frame(8'h77, 1'b0, 1'b1);
        data_rx = 1'b1;
        tick(2 * OS);
        expect_one("after_rst", 8'h77, 1'b0, 1'b0);

        // Randomized frames with occasional short glitches in the gaps
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, par, stop);
            exp_q.push_back('{d, model_pe(d, par), ~stop});
            data_rx = 1'b1;
            gap = stop ? $urandom_range(0, 2 * OS) : $urandom_range(OS, 2 * OS);
            tick(gap);
            if ($urandom_range(0, 3) == 0) begin
                if (gap < OS) tick(OS);
                data_rx = 1'b0;
                tick($urandom_range(1, 6));
                data_rx = 1'b1;
                tick(2 * OS);
            end
        end
        data_rx = 1'b1;
        tick(3 * OS);
        chk("rand_count", pending(), exp_q.size());
        for (int k = 0; k < exp_q.size() && (rd + k) < pulses.size(); k++) begin
            chk($sformatf("rand%0d_data", k), pulses[rd + k].d, exp_q[k].d);
            chk($sformatf("rand%0d_status", k), {pulses[rd + k].pe, pulses[rd + k].fe},
                {exp_q[k].pe, exp_q[k].fe});
        end
        rd = pulses.size();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
